systolic_pass_buffer: RTL
=========================

# systolic_pass_buffer

Parametrised inter-pass boundary buffer and pass sequencer for the multi-pass two-piece affine-gap systolic array. It captures the last-PE output stream (H, F, F̂, running max) of one pass. On the next pass it replays that stream into PE0 under a ready/valid handshake, and it injects the first-row boundary values on pass 0. It generalises the fixed 16-bit, single-ring controller with four additions: parametric widths and depth, a saturating pass counter, global best-score/position tracking, and a sticky overflow flag.

## Interface
Parameters:
- CALC_WIDTH, 16, signed score width
- ADDR_WIDTH, 10, row-index / coordinate width
- DEPTH, 1024, buffer entries; must be ≤ 2^ADDR_WIDTH
- PASS_WIDTH, 4, pass counter width
- MIN_VAL, 1024, magnitude of the boundary "−∞" used for F and F̂

Ports:
- clk  in  1  clock
- reset_i  in  1  synchronous, active-high reset
- new_seq  in  1  new sequence pair: clear pass count, best, overflow, stored rows
- start  in  1  begin a pass
- busy  out  1  high while a pass runs
- done  out  1  one-cycle pulse at pass end
- pass_idx  out  PASS_WIDTH  index of the current or next pass
- in_valid  in  1  last-PE output valid
- in_h, in_f, in_fh, in_max  in  CALC_WIDTH each  last-PE H, F, F̂, running max (signed)
- in_x, in_y  in  ADDR_WIDTH each  coordinates of in_max
- feed_ready  in  1  PE0 accepts a row this cycle
- feed_valid  out  1  feed data valid
- feed_h, feed_f, feed_fh, feed_max  out  CALC_WIDTH each  row values presented to PE0
- best_score  out  CALC_WIDTH  best in_max seen this sequence
- best_x, best_y  out  ADDR_WIDTH each  coordinates of best_score
- overflow  out  1  sticky; set when a write arrives with the buffer full

## Operation
- State machine has two states, IDLE and RUN.
  - IDLE → RUN when start=1. busy=1 and feed_valid=1 exactly while in RUN.
  - RUN → IDLE when seen=1 and in_valid=0.
    - seen is a flag set by any in_valid=1 in RUN and cleared on entering RUN.
    - On this transition: done pulses; rows_prev ← wr_cnt; wr_cnt, rd_cnt ← 0; pass_idx increments, saturating at 2^PASS_WIDTH−1.
- Write path: in RUN, when in_valid=1 and wr_cnt<DEPTH, mem[wr_cnt] ← {in_h, in_f, in_fh, in_max} and wr_cnt increments. When in_valid=1 and wr_cnt==DEPTH, the write is dropped and overflow ← 1.
- Read path: on each feed_valid & feed_ready, rd_cnt increments, saturating at DEPTH.
  - If pass_idx==0 or rd_cnt≥rows_prev, the feed outputs the boundary row: h=0, f=fh=−MIN_VAL, max=0.
  - Otherwise it outputs mem[rd_cnt].
  - The read is asynchronous from the register array. A same-cycle write to the read address returns the old contents.
- Best tracking: on any accepted or dropped in_valid, if $signed(in_max) > best_score (strict), then best ← (in_max, in_x, in_y). Ties keep the earlier entry.
- new_seq is honoured only in IDLE. It clears pass_idx, rows_prev, best (score 0, x 0, y 0), and overflow. If new_seq and start arrive in the same cycle, the clear applies first and the RUN pass uses pass_idx=0.
- start, and new_seq, in RUN are ignored. in_valid in IDLE is ignored, with no write and no best update.

## Timing
- Reset values: state IDLE, busy 0, done 0, feed_valid 0, pass_idx 0, best_score/best_x/best_y 0, overflow 0, rows_prev 0, wr_cnt 0, rd_cnt 0. The feed data outputs show the boundary row.
- reset_i mid-RUN returns the block to IDLE on the next edge, with all state cleared and no done pulse.
- start sampled at edge t gives busy=1 and feed_valid=1 from cycle t+1.
- The feed path has zero-latency presentation: a handshake at edge t shows the next row from t+1.
- The write and best update are visible the cycle after the in_valid edge.
- done is high for the single cycle after the edge that samples in_valid=0 with seen=1. In that same cycle busy=0 and pass_idx is already incremented.
- Minimum pass length is 1 valid row. A pass with no in_valid never ends on its own; only reset_i exits it.

## Test plan
- Pass 0 boundary: reset; start; 4 handshakes with feed_ready=1 → feed_h=0, feed_f=feed_fh=−1024 every cycle. Then in_valid high for 4 cycles with in_h=10,11,12,13 and then low → done one cycle later, pass_idx=1, rows_prev=4.
- Replay: start pass 1 with feed_ready toggling 1,0,1,1,1,1 → feed_h sequence 10,(hold 11),11,12,13, then the boundary row 0/−1024 after the 4th accepted row.
- Best tracking: in_max 5@(1,1), 9@(2,3), 9@(4,4), 7@(5,5) → best_score=9, best_x=2, best_y=3.
- Overflow: DEPTH=4, 6 in_valid rows → overflow=1 and stays 1, rows_prev=4. new_seq in IDLE → overflow=0, pass_idx=0.
- Collisions: start and new_seq in RUN → no effect. new_seq+start in IDLE after pass 3 → RUN with pass_idx=0 and boundary feed. reset_i during RUN → IDLE, busy=0, no done.
- Saturation: PASS_WIDTH=2, 5 passes → pass_idx sequence 1,2,3,3,3.

Source files
------------

// File: rtl/systolic_pass_buffer_if.sv
// Row-stream bundle between the systolic array and the pass buffer:
// the last-PE output stream coming in and the PE0 feed going out.
interface systolic_pass_buffer_if #(
  parameter int CALC_WIDTH = 16,
  parameter int ADDR_WIDTH = 10
);
  logic                  in_valid;
  logic [CALC_WIDTH-1:0] in_h;
  logic [CALC_WIDTH-1:0] in_f;
  logic [CALC_WIDTH-1:0] in_fh;
  logic [CALC_WIDTH-1:0] in_max;
  logic [ADDR_WIDTH-1:0] in_x;
  logic [ADDR_WIDTH-1:0] in_y;
  logic                  feed_ready;
  logic                  feed_valid;
  logic [CALC_WIDTH-1:0] feed_h;
  logic [CALC_WIDTH-1:0] feed_f;
  logic [CALC_WIDTH-1:0] feed_fh;
  logic [CALC_WIDTH-1:0] feed_max;

  // Array side: produces the last-PE stream, consumes the feed.
  modport master (
    output in_valid, in_h, in_f, in_fh, in_max, in_x, in_y, feed_ready,
    input  feed_valid, feed_h, feed_f, feed_fh, feed_max
  );

  // Buffer side: captures the last-PE stream, presents the feed.
  modport slave (
    input  in_valid, in_h, in_f, in_fh, in_max, in_x, in_y, feed_ready,
    output feed_valid, feed_h, feed_f, feed_fh, feed_max
  );
endinterface

// File: rtl/systolic_pass_buffer.sv
// Inter-pass boundary buffer and pass sequencer: stores one pass's last-PE rows,
// replays them into PE0 on the next pass, and tracks best score and overflow.
module systolic_pass_buffer #(
  parameter int CALC_WIDTH = 16,
  parameter int ADDR_WIDTH = 10,
  parameter int DEPTH      = 1024,
  parameter int PASS_WIDTH = 4,
  parameter int MIN_VAL    = 1024
) (
  input  logic                         clk,
  input  logic                         reset_i,
  input  logic                         new_seq,
  input  logic                         start,
  output logic                         busy,
  output logic                         done,
  output logic [PASS_WIDTH-1:0]        pass_idx,
  output logic signed [CALC_WIDTH-1:0] best_score,
  output logic [ADDR_WIDTH-1:0]        best_x,
  output logic [ADDR_WIDTH-1:0]        best_y,
  output logic                         overflow,
  systolic_pass_buffer_if.slave        bus
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int ROW_W = 4 * CALC_WIDTH;
  localparam logic [CNT_W-1:0]             DEPTH_C  = CNT_W'(DEPTH);
  localparam logic [PASS_WIDTH-1:0]        PASS_MAX = {PASS_WIDTH{1'b1}};
  localparam logic signed [CALC_WIDTH-1:0] NEG_INF  = CALC_WIDTH'(-MIN_VAL);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  state_e                       state_q, state_d;
  logic                         seen_q, seen_d;
  logic                         done_q, done_d;
  logic [PASS_WIDTH-1:0]        pass_idx_q, pass_idx_d;
  logic [CNT_W-1:0]             wr_cnt_q, wr_cnt_d;
  logic [CNT_W-1:0]             rd_cnt_q, rd_cnt_d;
  logic [CNT_W-1:0]             rows_prev_q, rows_prev_d;
  logic                         overflow_q, overflow_d;
  logic signed [CALC_WIDTH-1:0] best_score_q, best_score_d;
  logic [ADDR_WIDTH-1:0]        best_x_q, best_x_d;
  logic [ADDR_WIDTH-1:0]        best_y_q, best_y_d;

  logic [ROW_W-1:0]             mem_q [DEPTH];
  logic                         mem_we_s;
  logic [IDX_W-1:0]             mem_waddr_s;
  logic [ROW_W-1:0]             mem_wdata_s;
  logic [ROW_W-1:0]             rd_row_s;
  logic                         use_boundary_s;

  // Next-state, counters, write request and best tracking.
  always_comb begin
    state_d      = state_q;
    seen_d       = seen_q;
    done_d       = 1'b0;
    pass_idx_d   = pass_idx_q;
    wr_cnt_d     = wr_cnt_q;
    rd_cnt_d     = rd_cnt_q;
    rows_prev_d  = rows_prev_q;
    overflow_d   = overflow_q;
    best_score_d = best_score_q;
    best_x_d     = best_x_q;
    best_y_d     = best_y_q;
    mem_we_s     = 1'b0;
    mem_waddr_s  = wr_cnt_q[IDX_W-1:0];
    mem_wdata_s  = {bus.in_h, bus.in_f, bus.in_fh, bus.in_max};

    case (state_q)
      IDLE: begin
        // The clear is applied before start so a combined request runs pass 0.
        if (new_seq) begin
          pass_idx_d   = '0;
          rows_prev_d  = '0;
          overflow_d   = 1'b0;
          best_score_d = '0;
          best_x_d     = '0;
          best_y_d     = '0;
        end else begin
          pass_idx_d   = pass_idx_q;
        end
        if (start) begin
          state_d = RUN;
          seen_d  = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end

      RUN: begin
        if (bus.feed_ready && (rd_cnt_q != DEPTH_C)) begin
          rd_cnt_d = rd_cnt_q + CNT_W'(1);
        end else begin
          rd_cnt_d = rd_cnt_q;
        end

        if (bus.in_valid) begin
          seen_d = 1'b1;
          if (wr_cnt_q < DEPTH_C) begin
            mem_we_s = 1'b1;
            wr_cnt_d = wr_cnt_q + CNT_W'(1);
          end else begin
            overflow_d = 1'b1;
          end
          // Strict compare: on a tie the earlier coordinates are kept.
          if ($signed(bus.in_max) > best_score_q) begin
            best_score_d = $signed(bus.in_max);
            best_x_d     = bus.in_x;
            best_y_d     = bus.in_y;
          end else begin
            best_score_d = best_score_q;
          end
        end else if (seen_q) begin
          state_d     = IDLE;
          done_d      = 1'b1;
          rows_prev_d = wr_cnt_q;
          wr_cnt_d    = '0;
          rd_cnt_d    = '0;
          if (pass_idx_q != PASS_MAX) begin
            pass_idx_d = pass_idx_q + PASS_WIDTH'(1);
          end else begin
            pass_idx_d = pass_idx_q;
          end
        end else begin
          state_d = RUN;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Control and tracking registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset_i) begin
      state_q      <= IDLE;
      seen_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_idx_q   <= '0;
      wr_cnt_q     <= '0;
      rd_cnt_q     <= '0;
      rows_prev_q  <= '0;
      overflow_q   <= 1'b0;
      best_score_q <= '0;
      best_x_q     <= '0;
      best_y_q     <= '0;
    end else begin
      state_q      <= state_d;
      seen_q       <= seen_d;
      done_q       <= done_d;
      pass_idx_q   <= pass_idx_d;
      wr_cnt_q     <= wr_cnt_d;
      rd_cnt_q     <= rd_cnt_d;
      rows_prev_q  <= rows_prev_d;
      overflow_q   <= overflow_d;
      best_score_q <= best_score_d;
      best_x_q     <= best_x_d;
      best_y_q     <= best_y_d;
    end
  end

  // Row storage; contents beyond rows_prev are never presented, so no reset.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem_q[mem_waddr_s] <= mem_wdata_s;
    end
  end

  // Asynchronous replay read; rows not captured last pass become the boundary row.
  always_comb begin
    use_boundary_s = (pass_idx_q == '0) || (rd_cnt_q >= rows_prev_q);
    rd_row_s       = mem_q[rd_cnt_q[IDX_W-1:0]];
    if (use_boundary_s) begin
      bus.feed_h   = '0;
      bus.feed_f   = NEG_INF;
      bus.feed_fh  = NEG_INF;
      bus.feed_max = '0;
    end else begin
      bus.feed_h   = rd_row_s[4*CALC_WIDTH-1:3*CALC_WIDTH];
      bus.feed_f   = rd_row_s[3*CALC_WIDTH-1:2*CALC_WIDTH];
      bus.feed_fh  = rd_row_s[2*CALC_WIDTH-1:CALC_WIDTH];
      bus.feed_max = rd_row_s[CALC_WIDTH-1:0];
    end
  end

  assign bus.feed_valid = (state_q == RUN);
  assign busy           = (state_q == RUN);
  assign done           = done_q;
  assign pass_idx       = pass_idx_q;
  assign overflow       = overflow_q;
  assign best_score     = best_score_q;
  assign best_x         = best_x_q;
  assign best_y         = best_y_q;

endmodule
